// File: rtl/cone_launch_capture_pkg.sv
// Shared types and constants for the launch/capture cone tester.
// Holds the FSM encoding, the LFSR geometry and the MISR parameter defaults.
package cone_launch_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LFSR_W     = 7;
    localparam int LFSR_TAP_A = 6;
    localparam int LFSR_TAP_B = 5;
    localparam int COUNT_W    = 8;

    localparam int          SIG_W_DEFAULT    = 16;
    localparam logic [15:0] SIG_POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] SIG_INIT_DEFAULT = 16'h0000;

    // x^7 + x^6 + 1: maximal length, period 127
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/cone_launch_capture_if.sv
// Control, launch and capture signals between the tester and its environment.
// The slave side is the tester itself; the master side drives start and models the cone.
interface cone_launch_capture_if
    import cone_launch_capture_pkg::*;
#(
    parameter int SIG_W = SIG_W_DEFAULT
);
    logic                 start;
    logic [LFSR_W-1:0]    seed;
    logic [COUNT_W-1:0]   pattern_count;
    logic [LFSR_W-1:0]    cone_in;
    logic                 cone_out;
    logic                 busy;
    logic                 done;
    logic [SIG_W-1:0]     signature;

    modport master (
        output start, seed, pattern_count, cone_out,
        input  cone_in, busy, done, signature
    );

    modport slave (
        input  start, seed, pattern_count, cone_out,
        output cone_in, busy, done, signature
    );
endinterface

// File: rtl/cone_misr.sv
// Single-input MISR compacting one cone response bit per enabled cycle.
// clear has priority over enable so a new run always starts from SIG_INIT.
module cone_misr #(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SIG_INIT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] sig_reg;
    logic [SIG_W-1:0] sig_next;

    // Shift left, fold in the polynomial when the MSB falls out, inject din at bit 0
    for (genvar gi = 0; gi < SIG_W; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign sig_next[gi] = din ^ (sig_reg[SIG_W-1] & SIG_POLY[gi]);
        end else begin : g_upper
            assign sig_next[gi] = sig_reg[gi-1] ^ (sig_reg[SIG_W-1] & SIG_POLY[gi]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_reg <= SIG_INIT;
        end else if (clear) begin
            sig_reg <= SIG_INIT;
        end else if (enable) begin
            sig_reg <= sig_next;
        end
    end

    assign sig = sig_reg;
endmodule

// File: rtl/cone_launch_capture.sv
// Launch-on-LFSR / capture-into-MISR tester for one downstream combinational cone.
// Each RUN cycle launches cone_in from a register and captures cone_out at the next edge.
module cone_launch_capture
    import cone_launch_capture_pkg::*;
#(
    parameter int               SIG_W    = SIG_W_DEFAULT,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEFAULT),
    parameter logic [SIG_W-1:0] SIG_INIT = SIG_W'(SIG_INIT_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cone_launch_capture_if.slave   bus
);
    state_t               state_reg, state_next;
    logic [LFSR_W-1:0]    cone_in_reg, cone_in_next;
    logic [COUNT_W-1:0]   counter_reg, counter_next;
    logic [COUNT_W-1:0]   length_reg, length_next;
    logic                 misr_clear;
    logic                 misr_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cone_in_reg <= '0;
            counter_reg <= '0;
            length_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cone_in_reg <= cone_in_next;
            counter_reg <= counter_next;
            length_reg  <= length_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cone_in_next = cone_in_reg;
        counter_next = counter_reg;
        length_next  = length_reg;
        misr_clear   = 1'b0;
        misr_enable  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    misr_clear = 1'b1;
                    if (bus.pattern_count != '0) begin
                        state_next   = ST_RUN;
                        // All-zero is the LFSR lock-up state, so substitute 1
                        cone_in_next = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
                        counter_next = COUNT_W'(1);
                        length_next  = bus.pattern_count;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                misr_enable = 1'b1;
                if (counter_reg == length_reg) begin
                    state_next = ST_DONE;
                end else begin
                    cone_in_next = lfsr_next(cone_in_reg);
                    counter_next = counter_reg + COUNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    cone_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .SIG_INIT (SIG_INIT)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (misr_clear),
        .enable (misr_enable),
        .din    (bus.cone_out),
        .sig    (bus.signature)
    );

    assign bus.cone_in = cone_in_reg;
    assign bus.busy    = (state_reg == ST_RUN);
    assign bus.done    = (state_reg == ST_DONE);
endmodule

// File: tb/tb_cone_launch_capture.sv
// Self-checking bench: directed and randomized runs against a polynomial-arithmetic model.
// The downstream cone is modelled as a masked parity of cone_in, optionally inverted.
module tb_cone_launch_capture;
    import cone_launch_capture_pkg::*;

    localparam int          SIG_W    = 16;
    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [15:0] SIG_INIT = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cone_launch_capture_if #(.SIG_W(SIG_W)) bus ();

    logic [6:0] cone_mask = 7'h00;
    logic       cone_inv  = 1'b0;
    assign bus.cone_out = (^(bus.cone_in & cone_mask)) ^ cone_inv;

    cone_launch_capture #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .SIG_INIT (SIG_INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] idle_cone = 7'h00;
    logic [6:0] seen [1:255];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next pattern: multiply by x in the field defined by x^7+x^6+1 (shift, feedback = b6^b5)
    function automatic logic [6:0] ref_lfsr(input logic [6:0] v);
        logic [6:0] r;
        r = v << 1;
        r[0] = v[6] ^ v[5];
        return r;
    endfunction

    // Signature update as polynomial arithmetic: s*x + b reduced modulo x^16 + poly
    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic b);
        logic [16:0] w;
        w = {s, b};
        if (w[16]) w = w ^ {1'b1, SIG_POLY};
        return w[15:0];
    endfunction

    task automatic do_run(input logic [6:0] seed, input int count, input bit hold_start);
        logic [6:0]  pat;
        logic [15:0] sig;
        logic        resp;
        @(negedge clk);
        bus.start         = 1'b1;
        bus.seed          = seed;
        bus.pattern_count = 8'(count);
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        bus.seed          = 7'($urandom);
        bus.pattern_count = 8'($urandom);
        sig = SIG_INIT;
        pat = (seed == 7'h00) ? 7'h01 : seed;
        if (count == 0) begin
            check("zero_done",    32'(bus.done), 32'd1);
            check("zero_busy",    32'(bus.busy), 32'd0);
            check("zero_sig",     32'(bus.signature), 32'(SIG_INIT));
            check("zero_cone_in", 32'(bus.cone_in), 32'(idle_cone));
            bus.start = 1'b0;
            @(negedge clk);
            check("zero_done_clr", 32'(bus.done), 32'd0);
            check("zero_busy_clr", 32'(bus.busy), 32'd0);
            return;
        end
        for (int i = 1; i <= count; i++) begin
            check("run_busy",    32'(bus.busy), 32'd1);
            check("run_done",    32'(bus.done), 32'd0);
            check("run_cone_in", 32'(bus.cone_in), 32'(pat));
            check("run_sig",     32'(bus.signature), 32'(sig));
            seen[i] = bus.cone_in;
            resp = (^(pat & cone_mask)) ^ cone_inv;
            sig  = ref_misr(sig, resp);
            if (i < count) pat = ref_lfsr(pat);
            @(negedge clk);
        end
        check("end_done",    32'(bus.done), 32'd1);
        check("end_busy",    32'(bus.busy), 32'd0);
        check("end_sig",     32'(bus.signature), 32'(sig));
        check("end_cone_in", 32'(bus.cone_in), 32'(pat));
        idle_cone = pat;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_sig",  32'(bus.signature), 32'(sig));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start         = 1'b0;
        bus.seed          = 7'h00;
        bus.pattern_count = 8'h00;

        // Asynchronous reset, checked before any clock edge sees it
        #2 rst_n = 1'b0;
        #1;
        check("rst_state_busy", 32'(bus.busy), 32'd0);
        check("rst_state_done", 32'(bus.done), 32'd0);
        check("rst_cone_in",    32'(bus.cone_in), 32'h00);
        check("rst_sig",        32'(bus.signature), 32'(SIG_INIT));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: constant-0 cone, then constant-1 cone
        cone_mask = 7'h00; cone_inv = 1'b0;
        do_run(7'h01, 3, 1'b0);
        check("req028_seq3", 32'(seen[3]), 32'h04);
        cone_inv = 1'b1;
        do_run(7'h01, 3, 1'b0);
        check("req029_sig", 32'(bus.signature), 32'h0007);

        // Zero seed substitutes 1; zero count goes straight to DONE with start held
        do_run(7'h00, 1, 1'b0);
        check("req030_cone_in", 32'(seen[1]), 32'h01);
        do_run(7'h55, 0, 1'b1);

        // Full period wrap
        cone_mask = 7'h5a; cone_inv = 1'b0;
        do_run(7'h01, 128, 1'b1);
        begin
            bit used [0:127];
            int distinct;
            distinct = 0;
            for (int i = 0; i < 128; i++) used[i] = 1'b0;
            for (int i = 1; i <= 127; i++) begin
                if (seen[i] != 7'h00 && !used[seen[i]]) distinct++;
                used[seen[i]] = 1'b1;
            end
            check("wrap_distinct", 32'(distinct), 32'd127);
            check("wrap_p7",       32'(seen[7]), 32'h41);
            check("wrap_p128",     32'(seen[128]), 32'h01);
        end

        // Reset during pattern 2 of a 10-pattern run
        @(negedge clk);
        bus.start = 1'b1; bus.seed = 7'h01; bus.pattern_count = 8'd10;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_p2", 32'(bus.cone_in), 32'h02);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",    32'(bus.busy), 32'd0);
        check("abort_done",    32'(bus.done), 32'd0);
        check("abort_cone_in", 32'(bus.cone_in), 32'h00);
        check("abort_sig",     32'(bus.signature), 32'(SIG_INIT));
        @(negedge clk);
        rst_n = 1'b1;
        idle_cone = 7'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        do_run(7'h23, 5, 1'b0);

        // Randomized runs with random cones
        for (int r = 0; r < 10; r++) begin
            cone_mask = 7'($urandom);
            cone_inv  = 1'($urandom);
            do_run(7'($urandom), int'($urandom_range(0, 40)), 1'($urandom));
        end
        cone_mask = 7'($urandom);
        do_run(7'($urandom), 255, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cone_launch_capture.md
CONE_LAUNCH_CAPTURE -- requirements
Module: cone_launch_capture

Interface
REQ-001 SHALL have parameter SIG_W, default 16, signature (MISR) width.
REQ-002 SHALL have parameter SIG_POLY, default 16'h1021, MISR feedback polynomial, applied when the signature MSB is 1.
REQ-003 SHALL have parameter SIG_INIT, default 16'h0000, signature value after reset and on start.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request one test run; sampled only in IDLE.
REQ-007 seed  input  7  LFSR seed, latched on start.
REQ-008 pattern_count  input  8  number of launch patterns, latched on start.
REQ-009 cone_in  output  7  registered launch vector to the downstream combinational cone.
REQ-010 cone_out  input  1  cone response, captured at the end of each RUN cycle.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse when a run completes.
REQ-013 signature  output  SIG_W  MISR result; held stable from DONE until the next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE with start=1 and pattern_count!=0, SHALL on the next edge: enter RUN; load cone_in with seed (7'h01 if seed==0); set signature=SIG_INIT; set the pattern counter to 1; latch pattern_count.
REQ-016 In IDLE with start=1 and pattern_count==0, SHALL enter DONE with signature=SIG_INIT and cone_in unchanged.
REQ-017 In every RUN cycle, SHALL update signature as next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ {{SIG_W-1{1'b0}},cone_out}; this is a single-cycle launch-to-capture path.
REQ-018 In RUN, when counter==latched count, SHALL enter DONE on the same edge as the final capture and hold cone_in.
REQ-019 In RUN, when counter!=latched count, SHALL advance cone_in to {cone_in[5:0], cone_in[6]^cone_in[5]} (x^7+x^6+1, period 127) and increment the counter.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 start SHALL be ignored in RUN and DONE; changes to seed and pattern_count after start SHALL have no effect on the current run.
REQ-022 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL be registered or decoded from registered state only.
REQ-023 Sequences of 128 or more patterns SHALL wrap the LFSR: pattern 128 equals pattern 1.

Reset
REQ-024 rst_n low SHALL asynchronously force: state=IDLE, cone_in=7'h00, signature=SIG_INIT, counter=0, busy=0, done=0.
REQ-025 Reset asserted mid-RUN SHALL abort the run with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-026 Shared package SHALL hold the FSM state enum, the LFSR width (7), the LFSR tap positions, and the SIG_W/SIG_POLY/SIG_INIT defaults.
REQ-027 The MISR SHALL be a sub-module named cone_misr (ports clk, rst_n, clear, enable, din, sig).

Verification
REQ-028 seed=7'h01, count=3, cone_out=0 -> cone_in sequence 01,02,04; busy high for 3 cycles; done pulse; signature=16'h0000.
REQ-029 seed=7'h01, count=3, cone_out=1 -> signature steps 0001,0003,0007; final 16'h0007.
REQ-030 seed=7'h00, count=1 -> cone_in=7'h01; one RUN cycle; done on the next cycle.
REQ-031 seed=7'h01, count=128 -> 127 distinct nonzero cone_in values; pattern 128 equals 7'h01; the 7th value is 7'h41.
REQ-032 rst_n pulsed low during pattern 2 of a count=10 run -> outputs reach reset values immediately; no done pulse; start is accepted after release.
REQ-033 count=0 with start -> DONE the next cycle; busy never high; signature=SIG_INIT; start held high during RUN is ignored.
